fir_filter_param: RTL and testbench
===================================

// Module: fir_filter_param
// PURPOSE
//   Parametrised N-tap signed FIR filter; successor to the fixed 4-tap weighted FIR.
//   Adds runtime-loadable coefficients, valid/ready input handshake, output valid strobe,
//   synchronous reset and delay-line flush.
//   Uses one time-multiplexed multiply-accumulate: TAPS MAC cycles per accepted sample.
//   Sits between the sample source and the output-capture stage of the filter chain.
// PARAMETERS
//   DATA_W   16  input sample width, signed two's complement
//   COEF_W   16  coefficient width, signed two's complement
//   TAPS      4  number of taps, >= 2
//   OUT_W    36  accumulator/output width; must be >= DATA_W+COEF_W+$clog2(TAPS)
// PORTS
//   clk         in   1                clock, all logic on rising edge
//   rst_n       in   1                synchronous reset, active low
//   in_valid    in   1                in_sample is valid
//   in_ready    out  1                filter can accept a sample
//   in_sample   in   DATA_W           signed input sample
//   out_valid   out  1                one-cycle strobe: out_sample updated
//   out_sample  out  OUT_W            signed filter output, held until next result
//   coef_we     in   1                coefficient write enable
//   coef_addr   in   $clog2(TAPS)     tap index written (0 = newest sample)
//   coef_data   in   COEF_W           signed coefficient value
//   flush       in   1                clear delay line to zero
// BEHAVIOUR
//   Reset (rst_n=0 at a rising edge):
//     - state=IDLE; in_ready=1; out_valid=0; out_sample=0; delay line all 0.
//     - coef[0]=1, all other coef=0 (pass-through).
//     - Reset during MAC aborts the sample: no out_valid, partial sum discarded.
//   States:
//     - IDLE: in_ready=1.
//       - in_valid=1: shift the delay line, x[0]<=in_sample, x[k]<=x[k-1]; acc<=0; k<=0;
//         go to MAC.
//     - MAC: in_ready=0. Each cycle: acc<=acc+coef[k]*x[k], k<=k+1.
//       - When k=TAPS-1: out_sample<=final sum, out_valid<=1, go to IDLE.
//   Latency and throughput:
//     - Accept at edge E0; out_valid high for exactly one cycle after edge E0+TAPS.
//     - in_ready is high in that same cycle, so max throughput is 1 sample per TAPS+1 cycles.
//   Handshake:
//     - A transfer occurs only when in_valid&&in_ready at the edge.
//     - in_valid while busy is not consumed; the source holds the sample.
//     - The output has no backpressure.
//   Arithmetic:
//     - Products are full DATA_W+COEF_W signed, sign-extended to OUT_W.
//     - No rounding, saturation or truncation; with the OUT_W rule the sum never overflows.
//   Coefficient writes:
//     - Accepted only in IDLE (coef_we && state==IDLE); take effect from the next sample.
//     - coef_we during MAC is dropped. coef_addr >= TAPS is ignored.
//     - Write in the same IDLE cycle as a sample accept: the write applies, and the accepted
//       sample already uses the new value.
//   Flush:
//     - In IDLE: zero the delay line; flush wins over a same-cycle in_valid (no accept,
//       in_ready=1).
//     - In MAC: ignored. Coefficients and out_sample are unaffected.
// TESTING
//   1. Reset, then in_sample=100 valid 1 cycle -> out_valid 4 cycles after accept, out_sample=100.
//   2. Write coef={1,2,3,4}, feed 1,0,0,0,0 -> outputs 1,2,3,4,0.
//   3. All coef=-32768, four samples -32768 -> final out_sample=4294967296, no wrap.
//   4. Hold in_valid high continuously with values 5,6,... -> each accepted only when in_ready=1,
//      one result every 5 cycles, none lost or duplicated.
//   5. coef_we mid-MAC (addr 0, data 7) -> result unchanged, coef[0] still old value.
//      rst_n low mid-MAC -> no out_valid, out_sample=0.
//   6. After nonzero history, pulse flush in IDLE, then feed 0 -> out_sample=0.
//      flush with in_valid in the same cycle -> sample not accepted.

Source files
------------

// File: rtl/fir_filter_param.sv
// fir_filter_param: N-tap signed FIR, one time-multiplexed MAC, runtime-loadable coefficients.
// Latency: sample accepted at edge E0 -> out_valid strobes in the cycle after edge E0+TAPS.
// Backpressure: in_ready is low for the TAPS MAC cycles; the output has no backpressure.
module fir_filter_param #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 4,
  parameter int OUT_W  = 36
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_sample,
  output logic                    out_valid,
  output logic [OUT_W-1:0]        out_sample,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]       coef_data,
  input  logic                    flush
);
  localparam int KW = $clog2(TAPS);
  localparam int PW = DATA_W + COEF_W;

  typedef enum logic {IDLE, MAC} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] x_line [TAPS];
  logic [COEF_W-1:0] coef   [TAPS];
  logic [OUT_W-1:0]  acc;
  logic [KW-1:0]     k;

  logic              accept;
  logic              mac_last;
  logic              coef_wr;
  logic              flush_do;
  logic [DATA_W-1:0] x_cur;
  logic [COEF_W-1:0] c_cur;
  logic [PW-1:0]     x_ext;
  logic [PW-1:0]     c_ext;
  logic [PW-1:0]     prod;
  logic [OUT_W-1:0]  sum;

  // Single MAC: operands sign-extended to the full product width so the
  // product is exact, then sign-extended again into the accumulator width.
  assign x_cur = x_line[k];
  assign c_cur = coef[k];
  assign x_ext = {{COEF_W{x_cur[DATA_W-1]}}, x_cur};
  assign c_ext = {{DATA_W{c_cur[COEF_W-1]}}, c_cur};
  assign prod  = $signed(c_ext) * $signed(x_ext);
  assign sum   = acc + {{(OUT_W-PW){prod[PW-1]}}, prod};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and control strobes; flush takes priority over a sample accept.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    mac_last  = 1'b0;
    coef_wr   = 1'b0;
    flush_do  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        coef_wr  = coef_we;
        flush_do = flush;
        if (!flush && in_valid) begin
          accept    = 1'b1;
          state_nxt = MAC;
        end
      end
      MAC: begin
        if (k == KW'(TAPS-1)) begin
          mac_last  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Coefficient bank: pass-through after reset, writable only while idle.
  // Addresses with no matching tap decode to nothing and are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        coef[i] <= (i == 0) ? COEF_W'(1) : '0;
      end
    end else if (coef_wr) begin
      for (int i = 0; i < TAPS; i++) begin
        if (coef_addr == KW'(i)) begin
          coef[i] <= coef_data;
        end
      end
    end
  end

  // Delay line: x[0] is the newest sample; flush clears the history.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_do) begin
      for (int i = 0; i < TAPS; i++) begin
        x_line[i] <= '0;
      end
    end else if (accept) begin
      x_line[0] <= in_sample;
      for (int i = 1; i < TAPS; i++) begin
        x_line[i] <= x_line[i-1];
      end
    end
  end

  // Accumulator, tap counter and output register; out_valid is a single-cycle strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc        <= '0;
      k          <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        acc <= '0;
        k   <= '0;
      end else if (state == MAC) begin
        acc <= sum;
        k   <= k + KW'(1);
        if (mac_last) begin
          out_sample <= sum;
          out_valid  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_filter_param.sv
// Bench for fir_filter_param: randomized and directed stimulus against a queue-based
// reference model (dot product of coefficient table with the newest TAPS samples).
// Each scenario task performs its own comparisons; one summary line at the end.
module tb_fir_filter_param;
  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int TAPS   = 4;
  localparam int OUT_W  = 36;
  localparam int KW     = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_sample = '0;
  logic              out_valid;
  logic [OUT_W-1:0]  out_sample;
  logic              coef_we = 1'b0;
  logic [KW-1:0]     coef_addr = '0;
  logic [COEF_W-1:0] coef_data = '0;
  logic              flush = 1'b0;

  int errors = 0;
  int checks = 0;

  int coef_m [TAPS];
  int hist [$];

  fir_filter_param #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .out_valid(out_valid), .out_sample(out_sample),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .flush(flush)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int t = 0; t < TAPS; t++) coef_m[t] = (t == 0) ? 1 : 0;
    hist.delete();
  endfunction

  function automatic void model_push(input int v);
    hist.push_front(v);
    if (hist.size() > TAPS) void'(hist.pop_back());
  endfunction

  function automatic void model_flush();
    hist.delete();
  endfunction

  function automatic logic [OUT_W-1:0] model_out();
    longint s = 0;
    for (int t = 0; t < TAPS; t++)
      if (t < hist.size()) s += longint'(coef_m[t]) * longint'(hist[t]);
    return OUT_W'(s);
  endfunction

  // ---------------- drive helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int a, input int v);
    coef_we = 1'b1; coef_addr = KW'(a); coef_data = COEF_W'(v);
    tick();
    coef_we = 1'b0;
    coef_m[a] = v;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_flush();
  endtask

  task automatic wait_out(output logic [OUT_W-1:0] res, output int lat);
    lat = -1;
    res = 'x;
    for (int c = 1; c <= TAPS + 8; c++) begin
      tick();
      if (out_valid) begin
        lat = c;
        res = out_sample;
        break;
      end
    end
  endtask

  task automatic run_sample(input int v, output logic [OUT_W-1:0] res, output int lat);
    int n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    in_valid = 1'b1; in_sample = DATA_W'(v);
    tick();
    in_valid = 1'b0;
    model_push(v);
    wait_out(res, lat);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [OUT_W-1:0] res;
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; coef_we = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    model_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_sample !== '0) begin errors++; $display("FAIL reset_out_sample: got %0d expected 0", $signed(out_sample)); end
    run_sample(100, res, lat);
    checks++; if (lat !== TAPS) begin errors++; $display("FAIL first_latency: got %0d expected %0d", lat, TAPS); end
    checks++; if (res !== 36'd100) begin errors++; $display("FAIL passthrough: got %0d expected 100", $signed(res)); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL strobe_width: out_valid still %b one cycle later", out_valid); end
  endtask

  task automatic test_coef_load();
    logic [OUT_W-1:0] res;
    logic [OUT_W-1:0] e;
    int lat;
    int seq [5] = '{1, 0, 0, 0, 0};
    for (int a = 0; a < TAPS; a++) write_coef(a, a + 1);
    do_flush();
    for (int i = 0; i < 5; i++) begin
      run_sample(seq[i], res, lat);
      e = model_out();
      checks++; if (res !== e || lat !== TAPS) begin errors++; $display("FAIL impulse[%0d]: got %0d lat %0d expected %0d lat %0d", i, $signed(res), lat, $signed(e), TAPS); end
    end
  endtask

  task automatic test_extreme();
    logic [OUT_W-1:0] res;
    logic [OUT_W-1:0] e;
    int lat;
    for (int a = 0; a < TAPS; a++) write_coef(a, -32768);
    do_flush();
    for (int i = 0; i < TAPS; i++) run_sample(-32768, res, lat);
    e = model_out();
    checks++; if (res !== e) begin errors++; $display("FAIL extreme_model: got %0d expected %0d", $signed(res), $signed(e)); end
    checks++; if (res !== 36'd4294967296) begin errors++; $display("FAIL extreme_value: got %0d expected 4294967296", $signed(res)); end
  endtask

  task automatic test_back_to_back();
    int nxt = 5;
    int acc_cnt = 0;
    int out_cnt = 0;
    int last = -1;
    logic rb, iv;
    logic [OUT_W-1:0] e;
    logic [OUT_W-1:0] expq [$];
    write_coef(0, 1); write_coef(1, -1); write_coef(2, 2); write_coef(3, 3);
    in_valid = 1'b1; in_sample = DATA_W'(nxt);
    for (int cyc = 0; cyc < 80; cyc++) begin
      rb = in_ready; iv = in_valid;
      tick();
      if (rb && iv) begin
        model_push(nxt);
        expq.push_back(model_out());
        acc_cnt++; nxt++;
        if (acc_cnt == 10) in_valid = 1'b0;
        else in_sample = DATA_W'(nxt);
      end
      if (out_valid) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL b2b_extra: unexpected result %0d at cycle %0d", $signed(out_sample), cyc);
        end else begin
          e = expq.pop_front();
          if (out_sample !== e) begin errors++; $display("FAIL b2b_value: got %0d expected %0d", $signed(out_sample), $signed(e)); end
        end
        if (last >= 0) begin
          checks++; if (cyc - last != TAPS + 1) begin errors++; $display("FAIL b2b_gap: got %0d expected %0d", cyc - last, TAPS + 1); end
        end
        last = cyc; out_cnt++;
      end
    end
    in_valid = 1'b0;
    checks++; if (out_cnt !== 10) begin errors++; $display("FAIL b2b_count: got %0d expected 10", out_cnt); end
  endtask

  task automatic test_mac_coef_write();
    logic [OUT_W-1:0] res;
    logic [OUT_W-1:0] e;
    int lat;
    write_coef(0, 2); write_coef(1, 3); write_coef(2, 4); write_coef(3, 5);
    do_flush();
    in_valid = 1'b1; in_sample = DATA_W'(9);
    tick();
    in_valid = 1'b0;
    model_push(9);
    tick();
    coef_we = 1'b1; coef_addr = '0; coef_data = COEF_W'(7);
    tick();
    coef_we = 1'b0;
    wait_out(res, lat);
    e = model_out();
    checks++; if (res !== e) begin errors++; $display("FAIL mac_write_result: got %0d expected %0d", $signed(res), $signed(e)); end
    do_flush();
    run_sample(1, res, lat);
    e = model_out();
    checks++; if (res !== e) begin errors++; $display("FAIL mac_write_dropped: got %0d expected %0d", $signed(res), $signed(e)); end
  endtask

  task automatic test_reset_mid_mac();
    logic [OUT_W-1:0] res;
    logic [OUT_W-1:0] e;
    int lat;
    int seen = 0;
    in_valid = 1'b1; in_sample = DATA_W'(11);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < TAPS + 4; c++) begin
      if (out_valid) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_valid: got %0d strobes expected 0", seen); end
    checks++; if (out_sample !== '0) begin errors++; $display("FAIL abort_sample: got %0d expected 0", $signed(out_sample)); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", in_ready); end
    run_sample(37, res, lat);
    e = model_out();
    checks++; if (res !== e) begin errors++; $display("FAIL abort_coef_reset: got %0d expected %0d", $signed(res), $signed(e)); end
  endtask

  task automatic test_flush();
    logic [OUT_W-1:0] res;
    logic [OUT_W-1:0] e;
    int lat;
    int seen = 0;
    write_coef(0, 3); write_coef(1, 5); write_coef(2, 7); write_coef(3, 9);
    for (int i = 0; i < 3; i++) run_sample(int'($urandom_range(1000)) + 1, res, lat);
    do_flush();
    run_sample(0, res, lat);
    e = model_out();
    checks++; if (res !== '0 || res !== e) begin errors++; $display("FAIL flush_zero: got %0d expected %0d", $signed(res), $signed(e)); end
    run_sample(50, res, lat);
    flush = 1'b1; in_valid = 1'b1; in_sample = DATA_W'(123);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    model_flush();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_blocks_accept: in_ready got %b expected 1", in_ready); end
    for (int c = 0; c < TAPS + 2; c++) begin
      tick();
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_result: got %0d strobes expected 0", seen); end
    run_sample(0, res, lat);
    e = model_out();
    checks++; if (res !== e) begin errors++; $display("FAIL flush_history: got %0d expected %0d", $signed(res), $signed(e)); end
  endtask

  task automatic test_random();
    logic [OUT_W-1:0] res;
    logic [OUT_W-1:0] e;
    int lat;
    int v, a, c;
    for (int i = 0; i < 24; i++) begin
      v = int'($urandom_range(65535)) - 32768;
      a = int'($urandom_range(TAPS - 1));
      c = int'($urandom_range(65535)) - 32768;
      if ((i % 3) == 0) begin
        // coefficient write in the same cycle as the accept
        coef_we = 1'b1; coef_addr = KW'(a); coef_data = COEF_W'(c);
        in_valid = 1'b1; in_sample = DATA_W'(v);
        tick();
        coef_we = 1'b0; in_valid = 1'b0;
        coef_m[a] = c;
        model_push(v);
        wait_out(res, lat);
      end else begin
        if ((i % 3) == 1) write_coef(a, c);
        run_sample(v, res, lat);
      end
      e = model_out();
      checks++; if (res !== e || lat !== TAPS) begin errors++; $display("FAIL random[%0d]: got %0d lat %0d expected %0d lat %0d", i, $signed(res), lat, $signed(e), TAPS); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_coef_load();
    test_extreme();
    test_back_to_back();
    test_mac_coef_write();
    test_reset_mid_mac();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
